// File: rtl/fifo_mem_ctrl_if.sv
// rtl/fifo_mem_ctrl_if.sv - producer, consumer and memory-port bundle for fifo_mem_ctrl
interface fifo_mem_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  mem_write_en;
  logic [ADDR_WIDTH-1:0] mem_write_addr;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_read_en;
  logic [ADDR_WIDTH-1:0] mem_read_addr;
  logic [DATA_WIDTH-1:0] mem_read_data;

  // slave is the controller's view; master is the producer/consumer/memory side
  modport slave (
    input  in_valid, in_data, out_ready, mem_read_data,
    output in_ready, out_valid, out_data,
    output mem_write_en, mem_write_addr, mem_write_data, mem_read_en, mem_read_addr
  );

  modport master (
    output in_valid, in_data, out_ready, mem_read_data,
    input  in_ready, out_valid, out_data,
    input  mem_write_en, mem_write_addr, mem_write_data, mem_read_en, mem_read_addr
  );
endinterface

// File: rtl/fifo_mem_ctrl.sv
// rtl/fifo_mem_ctrl.sv - FWFT FIFO pointer/flow engine around a dual-port memory
// A two-entry output buffer hides the one-cycle memory read latency.
module fifo_mem_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  output logic [ADDR_WIDTH+1:0] count,
  fifo_mem_ctrl_if.slave        bus_io
);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   mem_count_q, mem_count_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [1:0]            occ_q, occ_d, occ_s;
  logic [DATA_WIDTH-1:0] obuf0_q, obuf0_d;
  logic [DATA_WIDTH-1:0] obuf1_q, obuf1_d;
  logic                  clr, push, pop, issue;
  logic [2:0]            slots;

  always_comb begin
    clr   = rst || flush;
    push  = bus_io.in_valid && (mem_count_q < DEPTH) && !clr;
    pop   = (occ_q != 2'd0) && bus_io.out_ready && !clr;
    // buffer slots that will be committed after this edge; issue only if one stays free
    slots = {1'b0, occ_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    issue = (mem_count_q != '0) && (slots < 3'd2) && !clr;
  end

  assign bus_io.in_ready       = (mem_count_q < DEPTH) && !clr;
  assign bus_io.out_valid      = (occ_q != 2'd0);
  assign bus_io.out_data       = obuf0_q;
  assign bus_io.mem_write_en   = push;
  assign bus_io.mem_write_addr = wr_ptr_q;
  assign bus_io.mem_write_data = bus_io.in_data;
  assign bus_io.mem_read_en    = issue;
  assign bus_io.mem_read_addr  = rd_ptr_q;

  assign count = (ADDR_WIDTH+2)'(mem_count_q) + (ADDR_WIDTH+2)'(rd_pend_q)
               + (ADDR_WIDTH+2)'(occ_q);

  always_comb begin
    wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(push);
    rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(issue);
    mem_count_d = mem_count_q + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(issue);
    rd_pend_d   = issue;
    obuf0_d     = obuf0_q;
    obuf1_d     = obuf1_q;
    occ_s       = occ_q;
    if (pop) begin
      obuf0_d = obuf1_q;
      occ_s   = occ_q - 2'd1;
    end
    occ_d = occ_s;
    // returning read lands in the lowest slot left free after the shift
    if (rd_pend_q) begin
      if (occ_s == 2'd0) begin
        obuf0_d = bus_io.mem_read_data;
      end else begin
        obuf1_d = bus_io.mem_read_data;
      end
      occ_d = occ_s + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      rd_pend_q   <= 1'b0;
      occ_q       <= 2'd0;
      obuf0_q     <= '0;
      obuf1_q     <= '0;
    end else if (flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      rd_pend_q   <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      rd_pend_q   <= rd_pend_d;
      occ_q       <= occ_d;
      obuf0_q     <= obuf0_d;
      obuf1_q     <= obuf1_d;
    end
  end
endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// tb/tb_fifo_mem_ctrl.sv - directed and randomized check of fifo_mem_ctrl against a queue model
module tb_fifo_mem_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [AW+1:0] count;

  fifo_mem_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .count  (count),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  // dual-port memory: synchronous write, registered read
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q;
  always @(posedge clk) begin
    if (bus.mem_write_en) mem[bus.mem_write_addr] <= bus.mem_write_data;
    if (bus.mem_read_en)  rd_q <= mem[bus.mem_read_addr];
  end
  assign bus.mem_read_data = rd_q;

  logic [DW-1:0] q[$];
  int            wr_cnt, rd_cnt;
  int            n_assert, n_fail;
  bit            chk_en;
  bit            push_s, pop_s, clr_s, rd_s;
  logic [DW-1:0] data_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    push_s = bus.in_valid && bus.in_ready;
    pop_s  = bus.out_valid && bus.out_ready;
    clr_s  = rst || flush;
    rd_s   = bus.mem_read_en;
    data_s = bus.in_data;
    if (chk_en) begin
      chk("count_vs_model", 32'(count), 32'(q.size()));
      chk("wen_is_push", 32'(bus.mem_write_en), 32'(push_s));
      if (clr_s) begin
        chk("clr_in_ready", 32'(bus.in_ready), 0);
        chk("clr_ren", 32'(bus.mem_read_en), 0);
      end
      if (bus.out_valid) begin
        chk("valid_nonempty", 32'(q.size() != 0), 1);
        if (q.size() != 0) chk("head_data", 32'(bus.out_data), 32'(q[0]));
      end
      if (bus.mem_write_en) begin
        chk("waddr", 32'(bus.mem_write_addr), 32'(wr_cnt % DEPTH));
        chk("wdata", 32'(bus.mem_write_data), 32'(bus.in_data));
      end
      if (bus.mem_read_en) chk("raddr", 32'(bus.mem_read_addr), 32'(rd_cnt % DEPTH));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (clr_s) begin
      q.delete();
      wr_cnt = 0;
      rd_cnt = 0;
    end else begin
      if (pop_s) void'(q.pop_front());
      if (push_s) begin
        q.push_back(data_s);
        wr_cnt++;
      end
      if (rd_s) rd_cnt++;
    end
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  int accepted, ndr, sent, recv, gaps, first_cyc;
  bit started, got;

  initial begin
    n_assert = 0; n_fail = 0; chk_en = 0; wr_cnt = 0; rd_cnt = 0;
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h5A; bus.out_ready = 1'b0;
    push_s = 0; pop_s = 0; rd_s = 0; data_s = '0;

    // reset held for three edges
    clr_s = 1'b1;
    advance();
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      chk("rst_wen", 32'(bus.mem_write_en), 0);
      chk("rst_ren", 32'(bus.mem_read_en), 0);
      advance();
    end
    rst = 1'b0; bus.in_valid = 1'b0;
    sample();
    chk("rel_in_ready", 32'(bus.in_ready), 1);
    chk("rel_out_valid", 32'(bus.out_valid), 0);
    chk("rel_count", 32'(count), 0);
    chk("rel_wen", 32'(bus.mem_write_en), 0);
    chk("rel_ren", 32'(bus.mem_read_en), 0);
    chk("rel_waddr", 32'(bus.mem_write_addr), 0);
    chk("rel_raddr", 32'(bus.mem_read_addr), 0);
    chk("rel_out_data", 32'(bus.out_data), 0);
    advance();

    // fall-through latency
    bus.in_valid = 1'b1; bus.in_data = 8'h11;
    sample();
    chk("ft_wen", 32'(bus.mem_write_en), 1);
    chk("ft_waddr", 32'(bus.mem_write_addr), 0);
    advance();
    bus.in_valid = 1'b0;
    sample();
    chk("ft_ren", 32'(bus.mem_read_en), 1);
    chk("ft_raddr", 32'(bus.mem_read_addr), 0);
    chk("ft_count_t1", 32'(count), 1);
    chk("ft_valid_t1", 32'(bus.out_valid), 0);
    advance();
    sample();
    chk("ft_count_t2", 32'(count), 1);
    chk("ft_valid_t2", 32'(bus.out_valid), 0);
    advance();
    sample();
    chk("ft_valid_t3", 32'(bus.out_valid), 1);
    chk("ft_data_t3", 32'(bus.out_data), 32'h11);
    chk("ft_count_t3", 32'(count), 1);
    advance();
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    sample();
    chk("ft_empty", 32'(bus.out_valid), 0);
    advance();

    // fill with consumer stalled
    accepted = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.in_data = 8'(32'h20 + accepted);
      sample();
      if (push_s) accepted++;
      advance();
    end
    bus.in_data = 8'(32'h20 + accepted);
    sample();
    chk("fill_accepted", 32'(accepted), 6);
    chk("fill_in_ready", 32'(bus.in_ready), 0);
    chk("fill_count", 32'(count), 6);
    chk("fill_head", 32'(bus.out_data), 32'h20);
    advance();

    // push and pop together while memory is full
    bus.out_ready = 1'b1;
    sample();
    chk("fullpop_in_ready", 32'(bus.in_ready), 0);
    chk("fullpop_valid", 32'(bus.out_valid), 1);
    advance();
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    sample();
    chk("fullpop_count", 32'(count), 5);
    advance();

    ndr = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      sample();
      if (pop_s) begin
        chk("drain_order", 32'(bus.out_data), 32'h21 + 32'(ndr));
        ndr++;
      end
      advance();
    end
    chk("drain_n", 32'(ndr), 5);
    bus.out_ready = 1'b0;

    // streaming through pointer wrap
    sent = 0; recv = 0; gaps = 0; started = 0; first_cyc = -1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 60 && recv < 20; c++) begin
      bus.in_valid = (sent < 20);
      bus.in_data  = 8'(sent);
      sample();
      if (bus.out_valid) begin
        if (!started) first_cyc = c;
        started = 1;
      end else if (started) begin
        gaps++;
      end
      if (pop_s) begin
        chk("stream_data", 32'(bus.out_data), 32'(recv));
        recv++;
      end
      if (push_s) sent++;
      advance();
    end
    bus.in_valid = 1'b0;
    chk("stream_recv", 32'(recv), 20);
    chk("stream_gaps", 32'(gaps), 0);
    chk("stream_latency", 32'(first_cyc), 3);

    // flush with a read in flight
    bus.out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = (accepted < 5);
      bus.in_data  = 8'(32'h30 + accepted);
      sample();
      if (push_s) accepted++;
      advance();
    end
    bus.in_valid = 1'b0;
    sample();
    chk("fl_count5", 32'(count), 5);
    advance();
    bus.out_ready = 1'b1;
    sample();
    chk("fl_issue", 32'(bus.mem_read_en), 1);
    advance();
    bus.out_ready = 1'b0; flush = 1'b1;
    sample();
    chk("fl_in_ready", 32'(bus.in_ready), 0);
    advance();
    flush = 1'b0;
    sample();
    chk("fl_count0", 32'(count), 0);
    chk("fl_valid0", 32'(bus.out_valid), 0);
    advance();
    bus.in_valid = 1'b1; bus.in_data = 8'hA5;
    cycle();
    bus.in_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      sample();
      if (bus.out_valid) begin
        got = 1;
        chk("fl_first_out", 32'(bus.out_data), 32'hA5);
      end
      advance();
    end
    chk("fl_got", 32'(got), 1);
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 149) == 0);
      flush         = ($urandom_range(0, 29) == 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < ((i < 200) ? 3 : 8));
      cycle();
    end
    rst = 1'b0; flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 30; i++) cycle();
    sample();
    chk("final_count", 32'(count), 0);
    chk("final_model_empty", 32'(q.size()), 0);
    chk("final_valid", 32'(bus.out_valid), 0);
    advance();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
